// File: rtl/div_arb_pkg.sv
// Shared types and constants for the two-requester divider arbiter.
// Optional remainder output is enabled by defining DIV_ARB_REM_EN.
package div_arb_pkg;

  localparam int DATA_W  = 4;
  localparam int NREQ    = 2;
  localparam int DIV_LAT = 4;
  localparam logic [DATA_W-1:0] DZ_QUOT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_arb_div.sv
// 4-bit restoring sequential divider: ld captures a/b, then one quotient bit
// per cycle for DIV_LAT cycles; y holds the quotient once the steps run out.
module div_arb_div
  import div_arb_pkg::*;
(
  input  logic              clk,
  input  logic              ld,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_b;
  logic [2:0]        r_steps;
  logic [DATA_W:0]   w_cat;
  logic [DATA_W-1:0] w_diff;

  // Partial remainder is always < b, so the difference fits in DATA_W bits.
  assign w_cat  = {r_rem, r_q[DATA_W-1]};
  assign w_diff = w_cat[DATA_W-1:0] - r_b;

  always_ff @(posedge clk) begin
    if (ld) begin
      r_rem   <= '0;
      r_q     <= a;
      r_b     <= b;
      r_steps <= 3'(DIV_LAT);
    end else if (r_steps != 3'd0) begin
      r_steps <= r_steps - 3'd1;
      if (w_cat >= {1'b0, r_b}) begin
        r_rem <= w_diff;
        r_q   <= {r_q[DATA_W-2:0], 1'b1};
      end else begin
        r_rem <= w_cat[DATA_W-1:0];
        r_q   <= {r_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign y = r_q;

endmodule

// File: rtl/div_arb.sv
// Round-robin arbiter time-sharing one sequential divider between two
// requesters. Define DIV_ARB_REM_EN to add the registered remainder output.
module div_arb
  import div_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic [NREQ-1:0]   ack,
  output logic [DATA_W-1:0] y,
  output logic              dz,
  output logic              busy,
  output state_t            o_dbg_state
`ifdef DIV_ARB_REM_EN
  ,
  output logic [DATA_W-1:0] rem
`endif
);

  localparam logic [1:0] RUN_LAST = 2'(DIV_LAT - 1);

  // Handshake: a requester raises req[i] with stable operands and holds both
  // until ack[i] pulses for one cycle; req[i] is not eligible during that pulse.
  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_g;
  logic              r_prio;
  logic [NREQ-1:0]   r_ack;
  logic [DATA_W-1:0] r_y;
  logic              r_dz;
  logic [NREQ-1:0]   w_elig;
  logic              w_gnt;
  logic [DATA_W-1:0] w_a_sel;
  logic [DATA_W-1:0] w_b_sel;
  logic              w_start;
  logic              w_b_zero;
  logic              w_ld;
  logic              w_busy;
  logic [DATA_W-1:0] w_div_y;

  assign w_elig   = req & ~r_ack;
  assign w_gnt    = (&w_elig) ? r_prio : w_elig[1];
  assign w_a_sel  = w_gnt ? a1 : a0;
  assign w_b_sel  = w_gnt ? b1 : b0;
  assign w_start  = (r_state == ST_IDLE) && (|w_elig);
  assign w_b_zero = (w_b_sel == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start && !w_b_zero) w_next = ST_LOAD;
      ST_LOAD: w_next = ST_RUN;
      ST_RUN:  if (r_cnt == RUN_LAST) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != ST_IDLE);
    w_ld   = (r_state == ST_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_g    <= 1'b0;
      r_prio <= 1'b0;
      r_ack  <= '0;
      r_y    <= '0;
      r_dz   <= 1'b0;
    end else begin
      r_ack <= '0;
      r_cnt <= (r_state == ST_RUN) ? r_cnt + 2'd1 : 2'd0;
      if (w_start) begin
        r_a <= w_a_sel;
        r_b <= w_b_sel;
        r_g <= w_gnt;
        // Zero divisor is answered straight from IDLE without touching the divider.
        if (w_b_zero) begin
          r_ack[w_gnt] <= 1'b1;
          r_y          <= DZ_QUOT;
          r_dz         <= 1'b1;
          r_prio       <= ~w_gnt;
        end
      end
      if (r_state == ST_DONE) begin
        r_ack[r_g] <= 1'b1;
        r_y        <= w_div_y;
        r_dz       <= 1'b0;
        r_prio     <= ~r_g;
      end
    end
  end

`ifdef DIV_ARB_REM_EN
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] w_yb;

  assign w_yb = w_div_y * r_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
    end else if (w_start && w_b_zero) begin
      r_rem <= w_a_sel;
    end else if (r_state == ST_DONE) begin
      r_rem <= r_a - w_yb;
    end
  end

  assign rem = r_rem;
`endif

  div_arb_div u_div (
    .clk (clk),
    .ld  (w_ld),
    .a   (r_a),
    .b   (r_b),
    .y   (w_div_y)
  );

  assign ack         = r_ack;
  assign y           = r_y;
  assign dz          = r_dz;
  assign busy        = w_busy;
  assign o_dbg_state = r_state;

endmodule
